// File: rtl/sum_window_averager.sv
// Collects 2**LOG2_N accepted samples and reports their rounded mean, min and max
// through a valid/ready handshake; one result per completed window.
module sum_window_averager #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LOG2_N = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_avg,
  output logic [DATA_W-1:0] out_min,
  output logic [DATA_W-1:0] out_max
);

  localparam int unsigned N     = 1 << LOG2_N;
  localparam int unsigned ACC_W = DATA_W + LOG2_N;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [LOG2_N-1:0]   count_q, count_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [DATA_W-1:0]   run_min_q, run_min_d;
  logic [DATA_W-1:0]   run_max_q, run_max_d;
  logic [DATA_W-1:0]   avg_d, min_d, max_d;

  logic                accept;
  logic                last_sample;
  logic [ACC_W-1:0]    acc_sum;
  logic [ACC_W-1:0]    rounded;
  logic [DATA_W-1:0]   sample_min;
  logic [DATA_W-1:0]   sample_max;

  // Handshake flags are pure decodes of the state flop.
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);

  assign accept      = in_valid & in_ready;
  assign last_sample = (count_q == LOG2_N'(N - 1));
  assign acc_sum     = acc_q + ACC_W'(in_data);
  // The half-up rounding sum always fits in ACC_W bits.
  assign rounded     = acc_sum + ACC_W'(N / 2);
  assign sample_min  = (in_data < run_min_q) ? in_data : run_min_q;
  assign sample_max  = (in_data > run_max_q) ? in_data : run_max_q;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ACCUM;
      count_q   <= '0;
      acc_q     <= '0;
      run_min_q <= '1;
      run_max_q <= '0;
      out_avg   <= '0;
      out_min   <= '0;
      out_max   <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      acc_q     <= acc_d;
      run_min_q <= run_min_d;
      run_max_q <= run_max_d;
      out_avg   <= avg_d;
      out_min   <= min_d;
      out_max   <= max_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    acc_d     = acc_q;
    run_min_d = run_min_q;
    run_max_d = run_max_q;
    avg_d     = out_avg;
    min_d     = out_min;
    max_d     = out_max;

    case (state_q)
      ACCUM: begin
        if (accept) begin
          if (last_sample) begin
            state_d   = HOLD;
            avg_d     = DATA_W'(rounded >> LOG2_N);
            min_d     = sample_min;
            max_d     = sample_max;
            count_d   = '0;
            acc_d     = '0;
            run_min_d = '1;
            run_max_d = '0;
          end else begin
            count_d   = count_q + LOG2_N'(1);
            acc_d     = acc_sum;
            run_min_d = sample_min;
            run_max_d = sample_max;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = ACCUM;
        end
      end
      default: begin
        state_d = ACCUM;
      end
    endcase
  end

endmodule

// File: tb/tb_sum_window_averager.sv
// Randomised and directed bench for sum_window_averager, checked against a
// queue-based window model (default N=4) plus a second LOG2_N=1 instance.
module tb_sum_window_averager;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_avg, out_min, out_max;

  logic       in_valid1 = 1'b0;
  logic       in_ready1;
  logic [7:0] in_data1 = 8'd0;
  logic       out_valid1;
  logic       out_ready1 = 1'b0;
  logic [7:0] out_avg1, out_min1, out_max1;

  int nchk = 0;
  int nerr = 0;

  // Reference model state for the N=4 instance.
  int   win_q[$];
  logic m_valid = 1'b0;
  int   m_avg = 0, m_min = 0, m_max = 0;

  always #5 clk = ~clk;

  sum_window_averager #(.DATA_W(8), .LOG2_N(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_avg(out_avg), .out_min(out_min), .out_max(out_max)
  );

  sum_window_averager #(.DATA_W(8), .LOG2_N(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_avg(out_avg1), .out_min(out_min1), .out_max(out_max1)
  );

  // Apply inputs for one rising edge, advance the model, settle 1ns after the edge.
  task automatic cycle(input logic v, input logic [7:0] d, input logic r);
    int sum, mn, mx;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    @(posedge clk);
    if (rst) begin
      win_q.delete();
      m_valid = 1'b0;
      m_avg = 0; m_min = 0; m_max = 0;
    end else if (!m_valid && v) begin
      win_q.push_back(int'(d));
      if (win_q.size() == 4) begin
        sum = 0; mn = 255; mx = 0;
        foreach (win_q[i]) begin
          sum += win_q[i];
          if (win_q[i] < mn) mn = win_q[i];
          if (win_q[i] > mx) mx = win_q[i];
        end
        m_avg = (sum + 2) / 4;
        m_min = mn;
        m_max = mx;
        m_valid = 1'b1;
        win_q.delete();
      end
    end else if (m_valid && r) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle(1'b0, 8'd0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    in_valid1 = 1'b0; out_ready1 = 1'b0;
    do_reset();
    nchk++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    nchk++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    nchk++; if (out_avg !== 8'd0) begin nerr++; $display("FAIL reset_out_avg got %0d want 0", out_avg); end
    nchk++; if (out_min !== 8'd0 || out_max !== 8'd0) begin nerr++; $display("FAIL reset_min_max got %0d/%0d want 0/0", out_min, out_max); end
    nchk++; if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin nerr++; $display("FAIL reset_dut1 got v=%0b r=%0b want 0/1", out_valid1, in_ready1); end
  endtask

  task automatic test_basic();
    cycle(1'b1, 8'd10, 1'b0);
    cycle(1'b1, 8'd20, 1'b0);
    cycle(1'b1, 8'd30, 1'b0);
    nchk++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL basic_early_valid got %0b want 0", out_valid); end
    cycle(1'b1, 8'd41, 1'b0);
    nchk++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin nerr++; $display("FAIL basic_valid got v=%0b r=%0b want 1/0", out_valid, in_ready); end
    nchk++; if (out_avg !== 8'd25) begin nerr++; $display("FAIL basic_avg got %0d want 25", out_avg); end
    nchk++; if (out_min !== 8'd10 || out_max !== 8'd41) begin nerr++; $display("FAIL basic_min_max got %0d/%0d want 10/41", out_min, out_max); end
    cycle(1'b0, 8'd0, 1'b1);
    nchk++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin nerr++; $display("FAIL basic_release got v=%0b r=%0b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_extremes();
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'd255, 1'b0);
    nchk++; if (out_valid !== 1'b1 || out_avg !== 8'd255) begin nerr++; $display("FAIL ones_avg got v=%0b avg=%0d want 1/255", out_valid, out_avg); end
    nchk++; if (out_min !== 8'd255 || out_max !== 8'd255) begin nerr++; $display("FAIL ones_min_max got %0d/%0d want 255/255", out_min, out_max); end
    cycle(1'b0, 8'd0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'd0, 1'b0);
    nchk++; if (out_valid !== 1'b1 || out_avg !== 8'd0 || out_min !== 8'd0 || out_max !== 8'd0) begin
      nerr++; $display("FAIL zeros got v=%0b %0d/%0d/%0d want 1 0/0/0", out_valid, out_avg, out_min, out_max);
    end
    cycle(1'b0, 8'd0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'd77, 1'b0);
    nchk++; if (out_avg !== 8'd77 || out_min !== 8'd77 || out_max !== 8'd77) begin
      nerr++; $display("FAIL equal got %0d/%0d/%0d want 77/77/77", out_avg, out_min, out_max);
    end
    cycle(1'b0, 8'd0, 1'b1);
  endtask

  task automatic test_backpressure();
    logic [7:0] s [4];
    int bad = 0;
    for (int i = 0; i < 4; i++) begin
      s[i] = 8'($urandom_range(0, 255));
      cycle(1'b1, s[i], 1'b0);
    end
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0);
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_avg !== 8'(m_avg) ||
          out_min !== 8'(m_min) || out_max !== 8'(m_max)) bad++;
    end
    nchk++; if (bad != 0) begin nerr++; $display("FAIL bp_hold got %0d unstable cycles want 0", bad); end
    nchk++; if (win_q.size() != 0 || out_avg !== 8'(m_avg)) begin nerr++; $display("FAIL bp_result got avg=%0d want %0d", out_avg, m_avg); end
    cycle(1'b1, 8'd99, 1'b1);
    nchk++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin nerr++; $display("FAIL bp_release got v=%0b r=%0b want 0/1", out_valid, in_ready); end
    nchk++; if (out_avg !== 8'(m_avg) || out_min !== 8'(m_min) || out_max !== 8'(m_max)) begin
      nerr++; $display("FAIL bp_retain got %0d/%0d/%0d want %0d/%0d/%0d", out_avg, out_min, out_max, m_avg, m_min, m_max);
    end
  endtask

  task automatic test_sparse();
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b1, 8'(i), 1'b1);
      if (i < 4) for (int k = 0; k < 3; k++) cycle(1'b0, 8'hEE, 1'b1);
    end
    nchk++; if (out_valid !== 1'b1 || out_avg !== 8'd3 || out_min !== 8'd1 || out_max !== 8'd4) begin
      nerr++; $display("FAIL sparse got v=%0b %0d/%0d/%0d want 1 3/1/4", out_valid, out_avg, out_min, out_max);
    end
    cycle(1'b0, 8'd0, 1'b1);
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 8'd200, 1'b0);
    cycle(1'b1, 8'd200, 1'b0);
    do_reset();
    cycle(1'b1, 8'd4, 1'b0);
    cycle(1'b1, 8'd4, 1'b0);
    cycle(1'b1, 8'd4, 1'b0);
    nchk++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL rstmid_early got %0b want 0", out_valid); end
    cycle(1'b1, 8'd8, 1'b0);
    nchk++; if (out_valid !== 1'b1 || out_avg !== 8'd5 || out_min !== 8'd4 || out_max !== 8'd8) begin
      nerr++; $display("FAIL rstmid got v=%0b %0d/%0d/%0d want 1 5/4/8", out_valid, out_avg, out_min, out_max);
    end
    // Reset while holding a result discards it.
    rst = 1'b1;
    cycle(1'b0, 8'd0, 1'b0);
    rst = 1'b0;
    nchk++; if (out_valid !== 1'b0 || out_avg !== 8'd0) begin nerr++; $display("FAIL rst_hold got v=%0b avg=%0d want 0/0", out_valid, out_avg); end
  endtask

  task automatic test_back_to_back();
    int windows = 0;
    int bad = 0;
    for (int i = 0; i < 15; i++) begin
      cycle(1'b1, 8'($urandom_range(0, 255)), 1'b1);
      if (out_valid === 1'b1) windows++;
      if (out_valid !== m_valid || out_avg !== 8'(m_avg) || out_min !== 8'(m_min) || out_max !== 8'(m_max)) bad++;
    end
    nchk++; if (windows != 3) begin nerr++; $display("FAIL b2b_windows got %0d want 3", windows); end
    nchk++; if (bad != 0) begin nerr++; $display("FAIL b2b_model got %0d bad cycles want 0", bad); end
    cycle(1'b0, 8'd0, 1'b1);
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      if (out_valid !== m_valid || in_ready !== !m_valid || out_avg !== 8'(m_avg) ||
          out_min !== 8'(m_min) || out_max !== 8'(m_max)) begin
        bad++;
        if (bad <= 5) $display("FAIL random cyc %0d got v=%0b %0d/%0d/%0d want v=%0b %0d/%0d/%0d",
                               i, out_valid, out_avg, out_min, out_max, m_valid, m_avg, m_min, m_max);
      end
    end
    nchk++; if (bad != 0) begin nerr++; $display("FAIL random_total got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_log2n1();
    int a, b, bad;
    in_valid1 = 1'b1; in_data1 = 8'd3; out_ready1 = 1'b0;
    @(posedge clk); #1;
    in_data1 = 8'd4;
    @(posedge clk); #1;
    nchk++; if (out_valid1 !== 1'b1 || out_avg1 !== 8'd4 || out_min1 !== 8'd3 || out_max1 !== 8'd4) begin
      nerr++; $display("FAIL n2 got v=%0b %0d/%0d/%0d want 1 4/3/4", out_valid1, out_avg1, out_min1, out_max1);
    end
    in_data1 = 8'd5; out_ready1 = 1'b1;
    @(posedge clk); #1;
    nchk++; if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin nerr++; $display("FAIL n2_gap got v=%0b r=%0b want 0/1", out_valid1, in_ready1); end
    @(posedge clk); #1;
    in_data1 = 8'd6;
    @(posedge clk); #1;
    nchk++; if (out_valid1 !== 1'b1 || out_avg1 !== 8'd6 || out_min1 !== 8'd5 || out_max1 !== 8'd6) begin
      nerr++; $display("FAIL n2_second got v=%0b %0d/%0d/%0d want 1 6/5/6", out_valid1, out_avg1, out_min1, out_max1);
    end
    in_valid1 = 1'b0;
    @(posedge clk); #1;
    bad = 0;
    for (int w = 0; w < 8; w++) begin
      a = $urandom_range(0, 255); b = $urandom_range(0, 255);
      out_ready1 = 1'b0; in_valid1 = 1'b1; in_data1 = 8'(a);
      @(posedge clk); #1;
      in_data1 = 8'(b);
      @(posedge clk); #1;
      if (out_valid1 !== 1'b1 || out_avg1 !== 8'((a + b + 1) / 2) ||
          out_min1 !== 8'((a < b) ? a : b) || out_max1 !== 8'((a > b) ? a : b)) bad++;
      in_valid1 = 1'b0; out_ready1 = 1'b1;
      @(posedge clk); #1;
    end
    nchk++; if (bad != 0) begin nerr++; $display("FAIL n2_random got %0d bad windows want 0", bad); end
    out_ready1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_backpressure();
    test_sparse();
    test_reset_mid();
    test_back_to_back();
    test_random();
    test_log2n1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end

endmodule
